vred_operand_seq: RTL and testbench

- Upstream issue stage for the vector reduction pipeline.
- Accepts one reduction command (op, SEW, vl, destination address, scalar seed vs1[0]), then consumes vs2 register-file beats.
- Replaces masked-off and tail elements with the op's identity value.
- Drives the reduction unit's per-beat interface (vec0, vec1, valid, start, end, opSel, sew, addr, lop_sum). That interface has no backpressure, so this block owns all flow control.

---
 rtl/vred_pkg.sv | 90 +++++++++
 rtl/vred_elem_fill.sv | 63 ++++++
 rtl/vred_operand_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_vred_operand_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vred_pkg.sv
// ============================================================================
// Module  : vred_pkg
// Purpose : Shared types and helpers for the vector-reduction operand
//           sequencer: op / SEW encodings, FSM state type, elements-per-beat
//           lookup, identity pattern generation and logical-op classification.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vred_pkg;

    typedef enum logic [2:0] {
        OP_SUM  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_MINU = 3'b100,
        OP_MIN  = 3'b101,
        OP_MAXU = 3'b110,
        OP_MAX  = 3'b111
    } vred_op_e;

    typedef enum logic [1:0] {
        SEW_E8  = 2'd0,
        SEW_E16 = 2'd1,
        SEW_E32 = 2'd2,
        SEW_E64 = 2'd3
    } vred_sew_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vred_state_e;

    // Elements per 64-bit beat for a given SEW code.
    function automatic logic [3:0] epb(input logic [1:0] sew);
        return 4'd8 >> sew;
    endfunction

    // log2 of epb(); used to turn an element count into a beat count.
    function automatic logic [1:0] epb_log2(input logic [1:0] sew);
        return 2'd3 - sew;
    endfunction

    // Sign bit of every lane, replicated across the beat.
    function automatic logic [63:0] lane_msb(input logic [1:0] sew);
        logic [63:0] r;
        case (sew)
            SEW_E8:  r = 64'h8080_8080_8080_8080;
            SEW_E16: r = 64'h8000_8000_8000_8000;
            SEW_E32: r = 64'h8000_0000_8000_0000;
            default: r = 64'h8000_0000_0000_0000;
        endcase
        return r;
    endfunction

    // All-ones in lane 0 only; masks a scalar down to one element.
    function automatic logic [63:0] lane0_ones(input logic [1:0] sew);
        logic [63:0] r;
        case (sew)
            SEW_E8:  r = 64'h0000_0000_0000_00FF;
            SEW_E16: r = 64'h0000_0000_0000_FFFF;
            SEW_E32: r = 64'h0000_0000_FFFF_FFFF;
            default: r = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return r;
    endfunction

    // Identity element of the reduction op, replicated into every lane so a
    // byte-wise select can substitute whole elements at any SEW.
    function automatic logic [63:0] identity(input logic [2:0] op,
                                             input logic [1:0] sew);
        logic [63:0] r;
        case (op)
            OP_AND, OP_MINU: r = 64'hFFFF_FFFF_FFFF_FFFF;
            OP_MIN:          r = ~lane_msb(sew);
            OP_MAX:          r = lane_msb(sew);
            default:         r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic logic is_logical(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vred_elem_fill.sv
// ============================================================================
// Module  : vred_elem_fill
// Purpose : Combinational per-element identity substitution. Each byte lane
//           belongs to element (byte >> sew); if that element is inactive the
//           byte is taken from the replicated identity pattern instead.
// Ports   : data_i  - vs2 beat, element 0 in LSBs
//           mask_i  - per-element active bits (bit i = element i)
//           count_i - elements of the command still outstanding (tail bound)
//           op_i    - reduction op
//           sew_i   - element width code
//           fill_o  - beat with inactive elements replaced by identity
// Config  : VRED_SEQ_MASK_EN - when defined mask_i gates elements; otherwise
//           only the tail bound applies.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vred_elem_fill
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int VL_WIDTH    = 12,
    parameter int OPSEL_WIDTH = 3,
    parameter int SEW_WIDTH   = 2
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] mask_i,
    input  logic [VL_WIDTH-1:0]     count_i,
    input  logic [OPSEL_WIDTH-1:0]  op_i,
    input  logic [SEW_WIDTH-1:0]    sew_i,
    output logic [DATA_WIDTH-1:0]   fill_o
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] ident;
    assign ident = identity(op_i, sew_i);

    for (genvar j = 0; j < NBYTES; j++) begin : g_byte
        localparam logic [2:0] BYTE_IDX = 3'(j);
        logic [2:0] elem_idx;
        logic       in_range;
        logic       active;

        assign elem_idx = BYTE_IDX >> sew_i;
        assign in_range = {{(VL_WIDTH-3){1'b0}}, elem_idx} < count_i;
`ifdef VRED_SEQ_MASK_EN
        assign active   = in_range & mask_i[elem_idx];
`else
        assign active   = in_range;
`endif
        assign fill_o[8*j +: 8] = active ? data_i[8*j +: 8] : ident[8*j +: 8];
    end

`ifdef VRED_SEQ_MASK_EN
`else
    logic unused_mask;
    assign unused_mask = ^mask_i;
`endif

endmodule

`default_nettype wire

// File: rtl/vred_operand_seq.sv
// ============================================================================
// Module  : vred_operand_seq
// Purpose : Issue stage for the vector reduction pipeline. Latches one
//           reduction command, consumes ceil(vl/EPB) vs2 beats, substitutes
//           identity for masked/tail elements and drives the registered
//           per-beat reduction interface (no backpressure downstream).
// Ports   : clk, rst (async, active-low)
//           cmd_*  - command handshake and fields (ready only in IDLE)
//           src_*  - vs2 beat handshake (ready only in RUN)
//           red_*  - registered beat to reduction unit, all 0 when not valid
//           busy   - state != IDLE
//           done   - one-cycle pulse at command completion
// Config  : VRED_SEQ_MASK_EN - honour src_mask (see vred_elem_fill).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vred_operand_seq
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int VL_WIDTH    = 12,
    parameter int OPSEL_WIDTH = 3,
    parameter int SEW_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPSEL_WIDTH-1:0]  cmd_op,
    input  logic [SEW_WIDTH-1:0]    cmd_sew,
    input  logic [VL_WIDTH-1:0]     cmd_vl,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_scalar,

    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic [DATA_WIDTH/8-1:0] src_mask,

    output logic [DATA_WIDTH-1:0]   red_vec0,
    output logic [DATA_WIDTH-1:0]   red_vec1,
    output logic                    red_valid,
    output logic                    red_start,
    output logic                    red_end,
    output logic [OPSEL_WIDTH-1:0]  red_opSel,
    output logic [SEW_WIDTH-1:0]    red_sew,
    output logic [ADDR_WIDTH-1:0]   red_addr,
    output logic                    red_lop_sum,

    output logic                    busy,
    output logic                    done
);

    localparam logic [VL_WIDTH:0]   VL_ONE   = {{VL_WIDTH{1'b0}}, 1'b1};
    localparam logic [VL_WIDTH-1:0] BEAT_ONE = {{(VL_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and latched command
    // ------------------------------------------------------------------
    vred_state_e             state_q, state_d;
    logic [OPSEL_WIDTH-1:0]  op_q, op_d;
    logic [SEW_WIDTH-1:0]    sew_q, sew_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   scalar_q, scalar_d;
    logic [VL_WIDTH-1:0]     elems_left_q, elems_left_d;
    logic [VL_WIDTH-1:0]     beats_left_q, beats_left_d;
    logic                    first_q, first_d;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   vec0_q, vec0_d;
    logic [DATA_WIDTH-1:0]   vec1_q, vec1_d;
    logic                    valid_q, valid_d;
    logic                    start_q, start_d;
    logic                    end_q, end_d;
    logic [OPSEL_WIDTH-1:0]  opsel_out_q, opsel_out_d;
    logic [SEW_WIDTH-1:0]    sew_out_q, sew_out_d;
    logic [ADDR_WIDTH-1:0]   addr_out_q, addr_out_d;
    logic                    lop_q, lop_d;
    logic                    done_q, done_d;

    // ------------------------------------------------------------------
    // Beat count for a new command: ceil(vl / EPB) = (vl + EPB - 1) >> log2(EPB)
    // One extra bit keeps the rounding add from overflowing.
    // ------------------------------------------------------------------
    logic [VL_WIDTH:0] round_up;
    logic [VL_WIDTH:0] beats_full;

    assign round_up   = {1'b0, cmd_vl} + {{(VL_WIDTH-3){1'b0}}, epb(cmd_sew)} - VL_ONE;
    assign beats_full = round_up >> epb_log2(cmd_sew);

    // Elements consumed per beat at the latched SEW
    logic [VL_WIDTH-1:0] epb_ext;
    assign epb_ext = {{(VL_WIDTH-4){1'b0}}, epb(sew_q)};

    logic [DATA_WIDTH-1:0] filled;

    vred_elem_fill #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VL_WIDTH    (VL_WIDTH),
        .OPSEL_WIDTH (OPSEL_WIDTH),
        .SEW_WIDTH   (SEW_WIDTH)
    ) u_fill (
        .data_i  (src_data),
        .mask_i  (src_mask),
        .count_i (elems_left_q),
        .op_i    (op_q),
        .sew_i   (sew_q),
        .fill_o  (filled)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign src_ready = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Next-state / output logic. Output registers default to 0 so every
    // non-beat cycle presents an all-zero red_* interface.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sew_d        = sew_q;
        addr_d       = addr_q;
        scalar_d     = scalar_q;
        elems_left_d = elems_left_q;
        beats_left_d = beats_left_q;
        first_d      = first_q;

        vec0_d       = '0;
        vec1_d       = '0;
        valid_d      = 1'b0;
        start_d      = 1'b0;
        end_d        = 1'b0;
        opsel_out_d  = '0;
        sew_out_d    = '0;
        addr_out_d   = '0;
        lop_d        = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    sew_d        = cmd_sew;
                    addr_d       = cmd_addr;
                    scalar_d     = cmd_scalar & lane0_ones(cmd_sew);
                    elems_left_d = cmd_vl;
                    beats_left_d = beats_full[VL_WIDTH-1:0];
                    first_d      = 1'b1;
                    if (cmd_vl == '0) begin
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (src_valid) begin
                    valid_d      = 1'b1;
                    start_d      = first_q;
                    end_d        = (beats_left_q == BEAT_ONE);
                    vec0_d       = filled;
                    vec1_d       = first_q ? scalar_q : '0;
                    opsel_out_d  = op_q;
                    sew_out_d    = sew_q;
                    addr_out_d   = addr_q;
                    lop_d        = is_logical(op_q);

                    first_d      = 1'b0;
                    beats_left_d = beats_left_q - BEAT_ONE;
                    // Saturate so the final partial beat leaves zero behind
                    elems_left_d = (elems_left_q > epb_ext) ? (elems_left_q - epb_ext) : '0;

                    if (beats_left_q == BEAT_ONE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            sew_q        <= '0;
            addr_q       <= '0;
            scalar_q     <= '0;
            elems_left_q <= '0;
            beats_left_q <= '0;
            first_q      <= 1'b0;
            vec0_q       <= '0;
            vec1_q       <= '0;
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            opsel_out_q  <= '0;
            sew_out_q    <= '0;
            addr_out_q   <= '0;
            lop_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sew_q        <= sew_d;
            addr_q       <= addr_d;
            scalar_q     <= scalar_d;
            elems_left_q <= elems_left_d;
            beats_left_q <= beats_left_d;
            first_q      <= first_d;
            vec0_q       <= vec0_d;
            vec1_q       <= vec1_d;
            valid_q      <= valid_d;
            start_q      <= start_d;
            end_q        <= end_d;
            opsel_out_q  <= opsel_out_d;
            sew_out_q    <= sew_out_d;
            addr_out_q   <= addr_out_d;
            lop_q        <= lop_d;
            done_q       <= done_d;
        end
    end

    assign red_vec0    = vec0_q;
    assign red_vec1    = vec1_q;
    assign red_valid   = valid_q;
    assign red_start   = start_q;
    assign red_end     = end_q;
    assign red_opSel   = opsel_out_q;
    assign red_sew     = sew_out_q;
    assign red_addr    = addr_out_q;
    assign red_lop_sum = lop_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vred_operand_seq.sv
// ============================================================================
// Module  : tb_vred_operand_seq
// Purpose : Self-checking bench for vred_operand_seq. Directed scenarios plus
//           randomized commands/beats compared against an element-level
//           reference model of the fill and beat-sequencing rules.
// Config  : VRED_SEQ_MASK_EN - model honours src_mask when defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vred_operand_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_sew = '0;
    logic [11:0] cmd_vl = '0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_scalar = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [63:0] src_data = '0;
    logic [7:0]  src_mask = '0;
    logic [63:0] red_vec0, red_vec1;
    logic        red_valid, red_start, red_end, red_lop_sum;
    logic [2:0]  red_opSel;
    logic [1:0]  red_sew;
    logic [31:0] red_addr;
    logic        busy, done;

    vred_operand_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sew(cmd_sew), .cmd_vl(cmd_vl), .cmd_addr(cmd_addr), .cmd_scalar(cmd_scalar),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_mask(src_mask),
        .red_vec0(red_vec0), .red_vec1(red_vec1), .red_valid(red_valid),
        .red_start(red_start), .red_end(red_end), .red_opSel(red_opSel),
        .red_sew(red_sew), .red_addr(red_addr), .red_lop_sum(red_lop_sum),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int last_end_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] beat_data [0:63];
    logic [7:0]  beat_mask [0:63];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lane_mask(input int sew);
        int w = 8 << sew;
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Expected filled beat, element by element.
    function automatic logic [63:0] model_beat(input int op, input int sew, input int vl,
                                               input int b, input logic [63:0] data,
                                               input logic [7:0] mask);
        int          w   = 8 << sew;
        int          epb = 8 >> sew;
        logic [63:0] lm  = lane_mask(sew);
        logic [63:0] res = '0;
        for (int e = 0; e < epb; e++) begin
            logic [63:0] elem, ident;
            bit          active;
            elem = (data >> (e * w)) & lm;
            case (op)
                1, 4:    ident = lm;                  // and, minu
                5:       ident = lm >> 1;             // min: 0111..1
                7:       ident = lm ^ (lm >> 1);      // max: 1000..0
                default: ident = '0;                  // sum, or, xor, maxu
            endcase
            active = ((b * epb + e) < vl);
`ifdef VRED_SEQ_MASK_EN
            active = active && mask[e];
`endif
            res = res | ((active ? elem : ident) << (e * w));
        end
        return res;
    endfunction

    // gap_mode: 0 none, 1 exactly one idle cycle before every beat after the
    // first, 2 random 0..2 idle cycles (with a stray cmd_valid) before any beat.
    task automatic run_cmd(input int op, input int sew, input int vl,
                           input logic [31:0] addr, input logic [63:0] scalar,
                           input int gap_mode, input bit chk_b2b);
        int epb = 8 >> sew;
        int nb  = (vl + epb - 1) / epb;
        cmd_valid  = 1'b1;
        cmd_op     = 3'(op);
        cmd_sew    = 2'(sew);
        cmd_vl     = 12'(vl);
        cmd_addr   = addr;
        cmd_scalar = scalar;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (vl == 0) begin
            check_eq("vl0_done", done, 1);
            check_eq("vl0_valid", red_valid, 0);
            check_eq("vl0_ready", cmd_ready, 1);
            @(posedge clk); #1;
            check_eq("vl0_done_pulse", done, 0);
            check_eq("vl0_valid2", red_valid, 0);
            return;
        end
        check_eq("run_busy", busy, 1);
        check_eq("run_cmd_ready", cmd_ready, 0);
        check_eq("run_src_ready", src_ready, 1);
        for (int b = 0; b < nb; b++) begin
            int ng;
            logic [63:0] exp;
            ng = (gap_mode == 1) ? ((b > 0) ? 1 : 0) :
                 (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                src_valid = 1'b0;
                if (gap_mode == 2) begin
                    cmd_valid = 1'($urandom);
                    cmd_op    = 3'($urandom);
                    cmd_vl    = 12'($urandom_range(1, 40));
                end
                @(posedge clk); #1;
                check_eq("gap_valid", red_valid, 0);
                check_eq("gap_vec0", red_vec0, 0);
                check_eq("gap_done", done, 0);
            end
            cmd_valid = 1'b0;
            src_valid = 1'b1;
            src_data  = beat_data[b];
            src_mask  = beat_mask[b];
            @(posedge clk); #1;
            src_valid = 1'b0;
            exp = model_beat(op, sew, vl, b, beat_data[b], beat_mask[b]);
            check_eq("beat_valid", red_valid, 1);
            check_eq("beat_start", red_start, (b == 0));
            check_eq("beat_end", red_end, (b == nb - 1));
            check_eq("beat_vec0", red_vec0, exp);
            check_eq("beat_vec1", red_vec1, (b == 0) ? (scalar & lane_mask(sew)) : 64'd0);
            check_eq("beat_opsel", red_opSel, op);
            check_eq("beat_sew", red_sew, sew);
            check_eq("beat_addr", red_addr, addr);
            check_eq("beat_lop", red_lop_sum, (op >= 1 && op <= 3));
            check_eq("beat_done", done, (b == nb - 1));
            check_eq("beat_cmd_ready", cmd_ready, (b == nb - 1));
            if (b == 0 && chk_b2b) check_eq("b2b_spacing", cyc - last_end_cyc, 2);
            if (b == nb - 1) last_end_cyc = cyc;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_src_ready", src_ready, 0);
        check_eq("rst_valid", red_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_vec0", red_vec0, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // sum, sew=0, vl=8, single beat
        beat_data[0] = 64'h0807_0605_0403_0201; beat_mask[0] = 8'hFF;
        run_cmd(0, 0, 8, 32'h1000, 64'd5, 0, 1'b0);

        // and, sew=1, vl=6, two beats of all ones
        beat_data[0] = '1; beat_mask[0] = 8'hFF;
        beat_data[1] = '1; beat_mask[1] = 8'hFF;
        run_cmd(1, 1, 6, 32'h2000, 64'hABCD_1234, 0, 1'b0);

        // max, sew=2, vl=3, mask 0b01
        beat_data[0] = 64'h1111_1111_2222_2222; beat_mask[0] = 8'h01;
        beat_data[1] = 64'h3333_3333_4444_4444; beat_mask[1] = 8'h01;
        run_cmd(7, 2, 3, 32'h3000, 64'hFFFF_FFFF_8765_4321, 0, 1'b0);

        // min, sew=3, partial mask/tail on 64-bit elements
        beat_data[0] = 64'h0123_4567_89AB_CDEF; beat_mask[0] = 8'h00;
        run_cmd(5, 3, 1, 32'h3100, 64'h55, 0, 1'b0);

        // vl = 0
        run_cmd(3, 0, 0, 32'h4000, 64'h7, 0, 1'b0);

        // Gapped 3-beat command, then an immediate second command
        for (int i = 0; i < 3; i++) begin
            beat_data[i] = {$urandom, $urandom}; beat_mask[i] = 8'($urandom);
        end
        run_cmd(0, 1, 12, 32'h5000, 64'h1234, 1, 1'b0);
        run_cmd(6, 0, 16, 32'h5100, 64'h99, 0, 1'b1);

        // Reset mid-RUN after beat 1 of 4
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_sew = 2'd0; cmd_vl = 12'd32;
        cmd_addr = 32'h6000; cmd_scalar = 64'h3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        src_valid = 1'b1; src_data = 64'hDEAD_BEEF_0000_0001; src_mask = 8'hFF;
        @(posedge clk); #1;
        check_eq("mid_beat0_valid", red_valid, 1);
        check_eq("mid_beat0_start", red_start, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", red_valid, 0);
        check_eq("mid_rst_vec0", red_vec0, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_valid", red_valid, 0);
        check_eq("post_rst_end", red_end, 0);
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("post_rst_src_ready", src_ready, 0);
        src_valid = 1'b0;

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            int op, sew, vl, epb, nb;
            op  = int'($urandom_range(0, 7));
            sew = int'($urandom_range(0, 3));
            vl  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            epb = 8 >> sew;
            nb  = (vl + epb - 1) / epb;
            for (int i = 0; i < nb; i++) begin
                beat_data[i] = {$urandom, $urandom};
                beat_mask[i] = 8'($urandom);
            end
            run_cmd(op, sew, vl, $urandom, {$urandom, $urandom}, 2, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
